// File: rtl/div_pkg.sv
// Shared constants, FSM state encoding and helpers for the signed
// non-restoring divider.
package div_pkg;

    localparam int WIDTH = 25;

    function automatic int iter_count(input int width);
        return width;
    endfunction

    localparam int ITERS = iter_count(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring iteration on {partial remainder, quotient}.
module div_step #(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic [WIDTH:0]   p_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted;

    // The sign of the incoming partial remainder picks add or subtract.
    always_comb begin
        shifted = {p_in[WIDTH-1:0], q_in[WIDTH-1]};
        p_out   = p_in[WIDTH] ? (shifted + {1'b0, d}) : (shifted - {1'b0, d});
        q_out   = {q_in[WIDTH-2:0], ~p_out[WIDTH]};
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Signed sequential divider: magnitudes are divided by a shared non-restoring
// step over WIDTH cycles, then remainder and signs are fixed in one cycle.
module nonrestoring_divider #(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovf
);

    import div_pkg::*;

    localparam int N_ITER = iter_count(WIDTH);
    localparam int CNT_W  = $clog2(N_ITER + 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d_mag;
    logic             sign_a;
    logic             sign_b;
    logic             zero_div;

    logic [WIDTH:0]   step_p;
    logic [WIDTH-1:0] step_q;
    logic             divisor_zero;
    logic             last_iter;

    logic [WIDTH:0]   rem_fix;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] dvd_res;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_in  (p),
        .q_in  (q),
        .d     (d_mag),
        .p_out (step_p),
        .q_out (step_q)
    );

    assign divisor_zero = (divisor == '0);
    assign last_iter    = (cnt == CNT_W'(N_ITER - 1));

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = divisor_zero ? FIX : CALC;
            CALC: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Final correction. With a zero divisor q still holds |dividend|, so
    // dvd_res restores the original dividend (including the most negative one).
    always_comb begin
        rem_fix = p[WIDTH] ? (p + {1'b0, d_mag}) : p;
        rem_mag = rem_fix[WIDTH-1:0];
        q_res   = (sign_a ^ sign_b) ? -q : q;
        r_res   = sign_a ? -rem_mag : rem_mag;
        dvd_res = sign_a ? -q : q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            p           <= '0;
            q           <= '0;
            d_mag       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            zero_div    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign_a      <= dividend[WIDTH-1];
                        sign_b      <= divisor[WIDTH-1];
                        q           <= dividend[WIDTH-1] ? -dividend : dividend;
                        d_mag       <= divisor[WIDTH-1] ? -divisor : divisor;
                        p           <= '0;
                        cnt         <= '0;
                        zero_div    <= divisor_zero;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        ovf         <= 1'b0;
                    end
                end
                CALC: begin
                    p   <= step_p;
                    q   <= step_q;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= dvd_res;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= q_res;
                        remainder <= r_res;
                        // Only -2^(W-1) / -1 yields a positive magnitude of 2^(W-1).
                        ovf       <= q[WIDTH-1] & ~(sign_a ^ sign_b);
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench: an arithmetic reference model drives a per-cycle
// compare process; directed vectors add hand-computed literal expectations.
module tb_nonrestoring_divider;

    localparam int W   = 25;
    localparam int LAT = 26;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;

    typedef struct {
        int   k;
        int   due;
        res_t res;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         ovf;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q_exp[$];

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed integer division truncating toward zero.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   m;
        longint sa, sb, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m.dz = 1'b0;
        m.ov = 1'b0;
        if (sb == 0) begin
            m.q  = '1;
            m.r  = a;
            m.dz = 1'b1;
        end else begin
            qq   = sa / sb;
            rr   = sa % sb;
            m.q  = qq[W-1:0];
            m.r  = rr[W-1:0];
            m.ov = (qq > ((longint'(1) << (W - 1)) - 1));
        end
        return m;
    endfunction

    // Compare process: every cycle after reset, check busy, done timing,
    // result values and output stability against the model queue.
    initial begin : compare
        logic [W-1:0] last_q;
        logic [W-1:0] last_r;
        exp_t         head;
        logic         exp_busy;
        last_q = '0;
        last_r = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_q = quotient;
                last_r = remainder;
            end else begin
                if (done) begin
                    if (q_exp.size() == 0) begin
                        check("spurious_done", 64'(done), 64'(0));
                    end else begin
                        head = q_exp.pop_front();
                        check("cmp_done_cycle", 64'(cyc), 64'(head.due));
                        check("cmp_quotient", 64'(quotient), 64'(head.res.q));
                        check("cmp_remainder", 64'(remainder), 64'(head.res.r));
                        check("cmp_div_by_zero", 64'(div_by_zero), 64'(head.res.dz));
                        check("cmp_ovf", 64'(ovf), 64'(head.res.ov));
                    end
                    check("cmp_busy_at_done", 64'(busy), 64'(0));
                end else begin
                    check("cmp_quotient_stable", 64'(quotient), 64'(last_q));
                    check("cmp_remainder_stable", 64'(remainder), 64'(last_r));
                    if (q_exp.size() != 0 && cyc > q_exp[0].due) begin
                        check("cmp_done_timeout", 64'(0), 64'(1));
                        void'(q_exp.pop_front());
                    end
                    exp_busy = (q_exp.size() != 0) && (cyc >= q_exp[0].k) && (cyc < q_exp[0].due);
                    check("cmp_busy", 64'(busy), 64'(exp_busy));
                end
                last_q = quotient;
                last_r = remainder;
            end
        end
    end

    // Called at negedge+2; start is sampled at the next rising edge (cycle k).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit expect_it, output int k);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        k        = cyc + 1;
        if (expect_it) begin
            e.k   = k;
            e.res = model(a, b);
            e.due = e.res.dz ? k + 1 : k + LAT;
            q_exp.push_back(e);
        end
        @(negedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #2;
        end
    endtask

    task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic eov);
        int   k;
        bit   seen;
        res_t m;
        m = model(a, b);
        check({name, "_model_q"}, 64'(m.q), 64'(eq));
        check({name, "_model_r"}, 64'(m.r), 64'(er));
        launch(a, b, 1'b1, k);
        wait_done(seen);
        check({name, "_latency"}, seen ? 64'(cyc - k) : 64'hFFFF, edz ? 64'(1) : 64'(LAT));
        check({name, "_quotient"}, 64'(quotient), 64'(eq));
        check({name, "_remainder"}, 64'(remainder), 64'(er));
        check({name, "_div_by_zero"}, 64'(div_by_zero), 64'(edz));
        check({name, "_ovf"}, 64'(ovf), 64'(eov));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_done"}, 64'(done), 64'(0));
        check({name, "_quotient"}, 64'(quotient), 64'(0));
        check({name, "_remainder"}, 64'(remainder), 64'(0));
        check({name, "_div_by_zero"}, 64'(div_by_zero), 64'(0));
        check({name, "_ovf"}, 64'(ovf), 64'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        bit seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #2;

        run("p100_d7",   25'd100,        25'd7,          25'd14,       25'd2,        1'b0, 1'b0);
        run("m100_d7",   -25'sd100,      25'd7,          25'h1FFFFF2,  25'h1FFFFFE,  1'b0, 1'b0);
        run("p7_d0",     25'd7,          25'd0,          25'h1FFFFFF,  25'd7,        1'b1, 1'b0);
        run("min_dm1",   25'h1000000,    25'h1FFFFFF,    25'h1000000,  25'd0,        1'b0, 1'b1);
        run("m100_dm7",  -25'sd100,      -25'sd7,        25'd14,       25'h1FFFFFE,  1'b0, 1'b0);
        run("p100_dm7",  25'd100,        -25'sd7,        25'h1FFFFF2,  25'd2,        1'b0, 1'b0);
        run("max_d1",    25'hFFFFFF,     25'd1,          25'hFFFFFF,   25'd0,        1'b0, 1'b0);
        run("min_d1",    25'h1000000,    25'd1,          25'h1000000,  25'd0,        1'b0, 1'b0);
        run("p5_d9",     25'd5,          25'd9,          25'd0,        25'd5,        1'b0, 1'b0);
        run("min_d0",    25'h1000000,    25'd0,          25'h1FFFFFF,  25'h1000000,  1'b1, 1'b0);
        run("max_dmin",  25'hFFFFFF,     25'h1000000,    25'd0,        25'hFFFFFF,   1'b0, 1'b0);

        // A start while busy must be ignored; the next start right after done is accepted.
        launch(25'd100, 25'd7, 1'b1, k);
        repeat (4) begin
            @(negedge clk);
            #2;
        end
        check("ignored_start_cycle", 64'(cyc + 1), 64'(k + 5));
        launch(25'd9, 25'd3, 1'b0, k);
        wait_done(seen);
        check("busy_run_seen", 64'(seen), 64'(1));
        check("busy_run_quotient", 64'(quotient), 64'(14));
        check("busy_run_remainder", 64'(remainder), 64'(2));
        run("b2b_p9_d3", 25'd9, 25'd3, 25'd3, 25'd0, 1'b0, 1'b0);

        // Reset in the middle of a divide: outputs clear at once, no done follows.
        launch(25'd100, 25'd7, 1'b1, k);
        repeat (10) begin
            @(negedge clk);
            #2;
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        q_exp.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run("after_reset", 25'd100, 25'd7, 25'd14, 25'd2, 1'b0, 1'b0);

        repeat (30) @(negedge clk);
        check("queue_drained", 64'(q_exp.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nonrestoring_divider.md
NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 25, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH bits: signed two's complement; sampled with start.
REQ-006 SHALL have port divisor, input, WIDTH bits: signed two's complement; sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: high while a divide is in progress.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse marking valid results.
REQ-009 SHALL have port quotient, output, WIDTH bits: signed result, truncated toward zero.
REQ-010 SHALL have port remainder, output, WIDTH bits: signed result; its sign follows the dividend, or it is zero.
REQ-011 SHALL have port div_by_zero, output, 1 bit: the divisor was zero; valid with done.
REQ-012 SHALL have port ovf, output, 1 bit: the true quotient is not representable; valid with done.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and FIX.
  - IDLE to CALC: on start.
  - CALC to FIX: after WIDTH iterations.
  - FIX to IDLE: unconditionally.
REQ-014 SHALL do the following when start=1 in IDLE at edge k:
  - latch |dividend|, |divisor| and both sign bits;
  - clear the (WIDTH+1)-bit partial remainder;
  - clear the iteration counter;
  - enter CALC.
REQ-015 SHALL perform one non-restoring step per CALC cycle:
  - shift {partial remainder, quotient register} left by 1;
  - add the divisor magnitude if the partial remainder is negative, otherwise subtract it;
  - set the new quotient LSB to the inverse of the result's sign.
REQ-016 SHALL do the following at edge k+26 (FIX):
  - add the divisor magnitude back if the final partial remainder is negative;
  - negate the quotient if the operand signs differ;
  - negate the remainder if the dividend is negative;
  - register quotient and remainder;
  - drive done=1 for exactly one cycle, i.e. a latency of 26 cycles;
  - return to IDLE.
REQ-017 SHALL hold busy=1 from edge k through edge k+26, and hold busy=0 in the cycle in which done=1.
REQ-018 SHALL ignore start while busy=1, with no effect on the running divide.
REQ-019 SHALL hold quotient, remainder, div_by_zero and ovf stable between done pulses.
REQ-020 SHALL, for a zero divisor at start:
  - skip CALC;
  - set quotient = all ones (-1), remainder = dividend and div_by_zero=1;
  - pulse done at edge k+1.
REQ-021 SHALL, for dividend = -2^(WIDTH-1) and divisor = -1, run the normal sequence and return quotient = -2^(WIDTH-1) (wrapped), remainder = 0 and ovf=1.
REQ-022 SHALL treat magnitudes as WIDTH-bit unsigned values, so that |-2^(WIDTH-1)| is exact, and carry the partial remainder in WIDTH+1 bits.
REQ-023 SHALL accept start in the cycle after done (back-to-back divides).
REQ-024 SHALL clear div_by_zero and ovf on each accepted start.

Reset
REQ-025 SHALL, on rst_n=0 and irrespective of clk:
  - force the state to IDLE;
  - clear busy, done, quotient, remainder, div_by_zero, ovf, the counter and all datapath registers.
REQ-026 SHALL, on reset mid-operation, abandon the divide without producing a done pulse, and accept start on the first edge after rst_n deasserts.

Structure
REQ-027 SHALL place WIDTH, the iteration count (= WIDTH) and the FSM state enumeration in shared package div_pkg.
REQ-028 SHALL place one combinational non-restoring iteration in sub-module div_step, instantiated once and reused every CALC cycle.

Verification
REQ-029 SHALL check start with 100 / 7 -> done at k+26, quotient=14, remainder=2, both flags 0.
REQ-030 SHALL check -100 / 7 -> quotient=-14 (25'h1FFFFF2), remainder=-2 (25'h1FFFFFE).
REQ-031 SHALL check 7 / 0 -> done at k+1, div_by_zero=1, quotient=25'h1FFFFFF, remainder=7.
REQ-032 SHALL check -16777216 / -1 -> quotient=25'h1000000, remainder=0, ovf=1.
REQ-033 SHALL check a second start pulsed at k+5 with 9/3 -> ignored; first result 100/7 unchanged; a start at the done cycle +1 with 9/3 -> quotient=3, remainder=0.
REQ-034 SHALL check rst_n pulsed low at k+10 -> all outputs 0 immediately, no done; a new 100/7 afterward -> correct result in 26 cycles.
